// File: rtl/memory_access.sv
// Memory-access pipeline stage: passes ALU results to write-back, or issues one
// aligned data-memory load/store and waits for the one-cycle completion ack.
// Load data is lane-extracted and sign/zero-extended before write-back.
module memory_access #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_in,
    input  logic [DATA_WIDTH-1:0]     alu_data_in,
    input  logic [DATA_WIDTH-1:0]     mem_data_in,
    input  logic                      mem_rd_in,
    input  logic                      mem_wr_in,
    input  logic [1:0]                mem_size_in,
    input  logic                      mem_signed_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_a_addr_in,
    input  logic                      reg_a_wr_ena_in,
    output logic [DATA_WIDTH-1:0]     dmem_addr_out,
    output logic [DATA_WIDTH-1:0]     dmem_wr_data_out,
    output logic [3:0]                dmem_byte_ena_out,
    output logic                      dmem_rd_req_out,
    output logic                      dmem_wr_req_out,
    input  logic                      dmem_ack_in,
    input  logic [DATA_WIDTH-1:0]     dmem_rd_data_in,
    output logic [DATA_WIDTH-1:0]     wb_reg_a_data_out,
    output logic [REG_ADDR_WIDTH-1:0] wb_reg_a_addr_out,
    output logic                      wb_reg_a_wr_ena_out,
    output logic                      stall_out,
    output logic                      misaligned_out
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic [3:0]                byte_ena_q, byte_ena_d;
    logic                      rd_req_q, rd_req_d;
    logic                      wr_req_q, wr_req_d;
    logic [1:0]                size_q, size_d;
    logic                      signed_q, signed_d;
    logic [1:0]                offset_q, offset_d;
    logic [REG_ADDR_WIDTH-1:0] dest_addr_q, dest_addr_d;
    logic                      dest_ena_q, dest_ena_d;
    logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
    logic [REG_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic                      wb_ena_q, wb_ena_d;
    logic                      misaligned_q, misaligned_d;

    logic                  mem_op;
    logic                  aligned;
    logic                  accept;
    logic                  reject;
    logic [3:0]            lane_ena;
    logic [DATA_WIDTH-1:0] store_data;
    logic [DATA_WIDTH-1:0] lane_shifted;
    logic [DATA_WIDTH-1:0] load_data;

    assign mem_op = mem_rd_in | mem_wr_in;

    // Alignment, lane enables and store-data replication for the offered access
    always_comb begin
        aligned    = 1'b1;
        lane_ena   = 4'b1111;
        store_data = mem_data_in;
        case (mem_size_in)
            2'b00: begin
                lane_ena   = 4'b0001 << alu_data_in[1:0];
                store_data = {(DATA_WIDTH/8){mem_data_in[7:0]}};
            end
            2'b01: begin
                aligned    = ~alu_data_in[0];
                lane_ena   = alu_data_in[1] ? 4'b1100 : 4'b0011;
                store_data = {(DATA_WIDTH/16){mem_data_in[15:0]}};
            end
            default: begin
                aligned    = (alu_data_in[1:0] == 2'b00);
            end
        endcase
    end

    assign accept = (state_q == IDLE) & valid_in & mem_op & aligned;
    assign reject = (state_q == IDLE) & valid_in & mem_op & ~aligned;

    // Pull the addressed lane down to bit 0 and extend it to full width
    always_comb begin
        lane_shifted = dmem_rd_data_in >> {offset_q, 3'b000};
        case (size_q)
            2'b00:   load_data = {{(DATA_WIDTH-8){signed_q & lane_shifted[7]}}, lane_shifted[7:0]};
            2'b01:   load_data = {{(DATA_WIDTH-16){signed_q & lane_shifted[15]}}, lane_shifted[15:0]};
            default: load_data = lane_shifted;
        endcase
    end

    // Upstream must hold while an access is being accepted or is still outstanding
    assign stall_out = accept | ((state_q == WAIT) & ~dmem_ack_in);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: enter WAIT on accept, leave on ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = WAIT;
            WAIT:    if (dmem_ack_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic: request capture, write-back selection, misalignment pulse
    always_comb begin
        addr_d       = addr_q;
        wr_data_d    = wr_data_q;
        byte_ena_d   = byte_ena_q;
        rd_req_d     = rd_req_q;
        wr_req_d     = wr_req_q;
        size_d       = size_q;
        signed_d     = signed_q;
        offset_d     = offset_q;
        dest_addr_d  = dest_addr_q;
        dest_ena_d   = dest_ena_q;
        wb_data_d    = wb_data_q;
        wb_addr_d    = wb_addr_q;
        wb_ena_d     = 1'b0;
        misaligned_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d      = {alu_data_in[DATA_WIDTH-1:2], 2'b00};
                    wr_data_d   = store_data;
                    byte_ena_d  = lane_ena;
                    // A combined read+write is treated as a plain store
                    rd_req_d    = mem_rd_in & ~mem_wr_in;
                    wr_req_d    = mem_wr_in;
                    size_d      = mem_size_in;
                    signed_d    = mem_signed_in;
                    offset_d    = alu_data_in[1:0];
                    dest_addr_d = reg_a_addr_in;
                    dest_ena_d  = reg_a_wr_ena_in;
                end else if (reject) begin
                    misaligned_d = 1'b1;
                end else if (valid_in) begin
                    wb_data_d = alu_data_in;
                    wb_addr_d = reg_a_addr_in;
                    wb_ena_d  = reg_a_wr_ena_in;
                end
            end
            WAIT: begin
                if (dmem_ack_in) begin
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    if (rd_req_q) begin
                        wb_data_d = load_data;
                        wb_addr_d = dest_addr_q;
                        wb_ena_d  = dest_ena_q;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears everything so a stale access cannot resume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            wr_data_q    <= '0;
            byte_ena_q   <= '0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            offset_q     <= '0;
            dest_addr_q  <= '0;
            dest_ena_q   <= 1'b0;
            wb_data_q    <= '0;
            wb_addr_q    <= '0;
            wb_ena_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            wr_data_q    <= wr_data_d;
            byte_ena_q   <= byte_ena_d;
            rd_req_q     <= rd_req_d;
            wr_req_q     <= wr_req_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            offset_q     <= offset_d;
            dest_addr_q  <= dest_addr_d;
            dest_ena_q   <= dest_ena_d;
            wb_data_q    <= wb_data_d;
            wb_addr_q    <= wb_addr_d;
            wb_ena_q     <= wb_ena_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign dmem_addr_out       = addr_q;
    assign dmem_wr_data_out    = wr_data_q;
    assign dmem_byte_ena_out   = byte_ena_q;
    assign dmem_rd_req_out     = rd_req_q;
    assign dmem_wr_req_out     = wr_req_q;
    assign wb_reg_a_data_out   = wb_data_q;
    assign wb_reg_a_addr_out   = wb_addr_q;
    assign wb_reg_a_wr_ena_out = wb_ena_q;
    assign misaligned_out      = misaligned_q;

endmodule
